// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - fetch stage control, memory and IF/ID bundle
//
// Purpose: groups the fetch stage's handshake and bus signals.
//   master : the fetch stage itself (drives IMemAddress and IF/ID outputs)
//   slave  : the surrounding pipeline / instruction memory / testbench
// Signals:
//   Stall, Flush, Redirect, RedirectPC : pipeline control into the stage
//   IMemAddress, IMemInstruction       : asynchronous instruction memory port
//   IFID_Instruction, IFID_PCPlus4,
//   IFID_Valid                         : IF/ID pipeline register contents
//   AlignErr                           : misaligned redirect target pulse
interface instruction_fetch_stage_if;
  logic        Stall;
  logic        Flush;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        AlignErr;

  modport master (
    input  Stall, Flush, Redirect, RedirectPC, IMemInstruction,
    output IMemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, AlignErr
  );

  modport slave (
    output Stall, Flush, Redirect, RedirectPC, IMemInstruction,
    input  IMemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, AlignErr
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC register, instruction fetch and IF/ID register
//
// Purpose: holds the program counter, presents it to the instruction memory,
// and captures the returned word plus PC+4 into the IF/ID register, honouring
// stall, flush and branch/jump redirect.
// Ports:
//   Clk    : rising-edge clock
//   Reset  : synchronous active-low reset (0 = reset)
//   bus    : instruction_fetch_stage_if.master (control in, memory port, IF/ID out)
//   FetchCount, StallCount, FlushCount : 32-bit event counters, present only
//            when the IF_PERF_CNT_EN macro is defined
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                              Clk,
  input  logic                              Reset,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]                       FetchCount,
  output logic [31:0]                       StallCount,
  output logic [31:0]                       FlushCount,
`endif
  instruction_fetch_stage_if.master         bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        align_err_q, align_err_d;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        load_valid;

  assign pc_plus4 = pc_q + 32'd4;
  // A redirect squashes the word fetched down the wrong path, same as a flush.
  assign bubble     = bus.Flush | bus.Redirect;
  assign load_valid = ~bubble & ~bus.Stall;

  always_comb begin
    pc_d = pc_plus4;
    if (bus.Redirect) begin
      pc_d = {bus.RedirectPC[31:2], 2'b00};
    end else if (bus.Stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    ifid_instr_d = bus.IMemInstruction;
    ifid_pcp4_d  = pc_plus4;
    ifid_valid_d = 1'b1;
    if (bubble) begin
      ifid_instr_d = NOP_WORD;
      ifid_pcp4_d  = pc_plus4;
      ifid_valid_d = 1'b0;
    end else if (bus.Stall) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pcp4_d  = ifid_pcp4_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  assign align_err_d = bus.Redirect & (bus.RedirectPC[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_WORD;
      ifid_pcp4_q  <= 32'd0;
      ifid_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
      align_err_q  <= align_err_d;
    end
  end

  // Memory address comes straight from the PC register: no input-to-address path.
  assign bus.IMemAddress      = pc_q;
  assign bus.IFID_Instruction = ifid_instr_q;
  assign bus.IFID_PCPlus4     = ifid_pcp4_q;
  assign bus.IFID_Valid       = ifid_valid_q;
  assign bus.AlignErr         = align_err_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, load_valid};
    stall_cnt_d = stall_cnt_q + {31'd0, bus.Stall & ~bus.Redirect};
    flush_cnt_d = flush_cnt_q + {31'd0, bubble};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        align;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  logic [31:0] mem [1024];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  instruction_fetch_stage_if bus();

`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCount, StallCount, FlushCount;
`endif

  instruction_fetch_stage dut (
    .Clk        (Clk),
    .Reset      (Reset),
`ifdef IF_PERF_CNT_EN
    .FetchCount (FetchCount),
    .StallCount (StallCount),
    .FlushCount (FlushCount),
`endif
    .bus        (bus.master)
  );

  always #5 Clk = ~Clk;

  assign bus.IMemInstruction = mem[bus.IMemAddress[11:2]];

  function automatic logic [31:0] memw(input int idx);
    return (idx == 0) ? 32'h2008_0005 : (32'hA000_0000 | 32'(idx));
  endfunction

  function automatic stim_t S(input logic r, input logic s, input logic f,
                              input logic d, input logic [31:0] a);
    return '{rst_n: r, stall: s, flush: f, redir: d, rpc: a};
  endfunction

  function automatic exp_t E(input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v, input logic al);
    return '{pc: pc, instr: ins, pcp4: p4, valid: v, align: al};
  endfunction

  function automatic exp_t observe();
    return '{pc: bus.IMemAddress, instr: bus.IFID_Instruction,
             pcp4: bus.IFID_PCPlus4, valid: bus.IFID_Valid, align: bus.AlignErr};
  endfunction

  task automatic drive_edge(input stim_t st);
    Reset          = st.rst_n;
    bus.Stall      = st.stall;
    bus.Flush      = st.flush;
    bus.Redirect   = st.redir;
    bus.RedirectPC = st.rpc;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge(S(0, 0, 0, 0, 0));
    drive_edge(S(0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    for (int k = 0; k < 3; k++) begin
      st.push_back(S(0, 0, 0, 1, 32'h40));
      ex.push_back(E(0, 0, 0, 0, 0));
    end
    st.push_back(S(1, 0, 0, 0, 0));
    ex.push_back(E(4, 32'h2008_0005, 4, 1, 0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      drive_edge(st[i]);
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d] got pc=%h ins=%h p4=%h v=%b ae=%b want pc=%h ins=%h p4=%h v=%b ae=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.align,
                 want.pc, want.instr, want.pcp4, want.valid, want.align);
      end
    end
  endtask

  task automatic test_sequential();
    exp_t got, want;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back(E(32'(4 * (k + 1)), memw(k), 32'(4 * (k + 1)), 1, 0));
      drive_edge(S(1, 0, 0, 0, 0));
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sequential[%0d] got pc=%h ins=%h p4=%h v=%b ae=%b want pc=%h ins=%h p4=%h v=%b ae=%b",
                 k, got.pc, got.instr, got.pcp4, got.valid, got.align,
                 want.pc, want.instr, want.pcp4, want.valid, want.align);
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    do_reset();
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(4, memw(0), 4, 1, 0));
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(8, memw(1), 8, 1, 0));
    st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(E(8, memw(1), 8, 1, 0));
    st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(E(8, memw(1), 8, 1, 0));
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(12, memw(2), 12, 1, 0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      drive_edge(st[i]);
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall[%0d] got pc=%h ins=%h p4=%h v=%b ae=%b want pc=%h ins=%h p4=%h v=%b ae=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.align,
                 want.pc, want.instr, want.pcp4, want.valid, want.align);
      end
    end
  endtask

  task automatic test_redirect_stall();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    st.push_back(S(1, 1, 0, 1, 32'h0000_0103)); ex.push_back(E(32'h100, 0, 16, 0, 1));
    st.push_back(S(1, 0, 0, 0, 0));             ex.push_back(E(32'h104, memw(64), 32'h104, 1, 0));
    st.push_back(S(1, 0, 0, 0, 0));             ex.push_back(E(32'h108, memw(65), 32'h108, 1, 0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      drive_edge(st[i]);
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect_stall[%0d] got pc=%h ins=%h p4=%h v=%b ae=%b want pc=%h ins=%h p4=%h v=%b ae=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.align,
                 want.pc, want.instr, want.pcp4, want.valid, want.align);
      end
    end
  endtask

  task automatic test_flush_stall();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    do_reset();
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(4, memw(0), 4, 1, 0));
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(8, memw(1), 8, 1, 0));
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(12, memw(2), 12, 1, 0));
    st.push_back(S(1, 1, 1, 0, 0)); ex.push_back(E(12, 0, 16, 0, 0));
    st.push_back(S(1, 0, 0, 0, 0)); ex.push_back(E(16, memw(3), 16, 1, 0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      drive_edge(st[i]);
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL flush_stall[%0d] got pc=%h ins=%h p4=%h v=%b ae=%b want pc=%h ins=%h p4=%h v=%b ae=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.align,
                 want.pc, want.instr, want.pcp4, want.valid, want.align);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    do_reset();
    st.push_back(S(1, 0, 1, 1, 32'hFFFF_FFFC)); ex.push_back(E(32'hFFFF_FFFC, 0, 4, 0, 0));
    st.push_back(S(1, 0, 0, 0, 0));             ex.push_back(E(0, memw(1023), 0, 1, 0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      drive_edge(st[i]);
      got = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d] got pc=%h ins=%h p4=%h v=%b ae=%b want pc=%h ins=%h p4=%h v=%b ae=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.align,
                 want.pc, want.instr, want.pcp4, want.valid, want.align);
      end
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (FetchCount !== 32'd1) begin
      errors++;
      $display("FAIL fetch_count got %0d want 1", FetchCount);
    end
    checks++;
    if (FlushCount !== 32'd1) begin
      errors++;
      $display("FAIL flush_count got %0d want 1", FlushCount);
    end
    checks++;
    if (StallCount !== 32'd0) begin
      errors++;
      $display("FAIL stall_count got %0d want 0", StallCount);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = memw(i);
    Reset          = 1'b0;
    bus.Stall      = 1'b0;
    bus.Flush      = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_flush_stall();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage feeding the 1024-word, asynchronously-read, byte-addressed instruction memory.
- Holds the program counter (PC) and drives it as the memory address.
- Captures the returned instruction, plus PC+4, into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from downstream stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset (0 = reset).
- Stall  input  1  hazard stall: hold PC and IF/ID contents.
- Flush  input  1  replace next IF/ID contents with a bubble.
- Redirect  input  1  load PC from RedirectPC (taken branch/jump).
- RedirectPC  input  32  redirect target byte address.
- IMemAddress  output  32  current PC, driven to instruction memory Address.
- IMemInstruction  input  32  instruction word returned combinationally for IMemAddress.
- IFID_Instruction  output  32  registered instruction.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- AlignErr  output  1  one-cycle pulse: redirect target was not word-aligned.

Behaviour:
- Reset is sampled on the Clk edge while Reset==0:
  - PC=RESET_PC.
  - IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, AlignErr=0.
  - Reset dominates all other inputs, including mid-stall or mid-redirect.
- IMemAddress = PC, purely from the register. No combinational path from any input.
- Latency: word at PC appears on IFID_Instruction one edge after PC is presented.
- PC update priority, per edge when Reset==1:
  - Redirect: PC = {RedirectPC[31:2],2'b00}. Redirect overrides Stall.
  - else Stall: PC holds.
  - else: PC = PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority, per edge:
  - Flush or Redirect: IFID_Instruction=NOP_WORD, IFID_Valid=0, IFID_PCPlus4=PC+4 (debug only).
  - else Stall: all IF/ID fields hold.
  - else: IFID_Instruction=IMemInstruction, IFID_PCPlus4=PC+4, IFID_Valid=1.
- Flush+Stall: IF/ID becomes a bubble, PC holds.
- Redirect+Flush: identical to Redirect alone.
- AlignErr is registered, high for exactly one cycle after an edge where Redirect==1 and RedirectPC[1:0]!=0. Otherwise 0.
- Addresses beyond memory depth alias; the memory uses bits [11:2]. No bounds check in this block.
- First edge after reset release: IF/ID captures word at RESET_PC, IFID_Valid=1, PC=RESET_PC+4.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs FetchCount, StallCount, FlushCount (each 32 bits, wrap on overflow, cleared by Reset).
  - FetchCount increments on each edge where IF/ID loads a valid instruction.
  - StallCount increments on each edge with Stall==1 and Redirect==0.
  - FlushCount increments on each edge with Flush==1 or Redirect==1.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold Reset=0 for 3 edges with Redirect=1, RedirectPC=32'h40.
  - Required: PC=0, IFID_Valid=0, IFID_Instruction=0.
  - Release with memory[0]=32'h2008_0005: next edge gives IFID_Instruction=32'h2008_0005, IFID_PCPlus4=4, IMemAddress=4.
- Sequential fetch: 5 free-running edges.
  - Required: IMemAddress 4,8,12,16,20.
  - IFID_PCPlus4 trails IMemAddress by one edge with matching memory words.
- Stall: Stall=1 for 2 edges at PC=8.
  - Required: PC stays 8, IF/ID unchanged, IFID_Valid unchanged.
  - On release, IF/ID captures memory[2].
- Redirect during stall: Stall=1, Redirect=1, RedirectPC=32'h0000_0103.
  - Required: PC=32'h100, IFID_Valid=0, AlignErr=1 for exactly one cycle.
  - Next edge (Stall=0): IF/ID holds memory[64].
- Flush vs stall: Flush=1 and Stall=1 at PC=12.
  - Required: PC stays 12, IFID_Instruction=0, IFID_Valid=0.
- Wrap: Redirect to 32'hFFFF_FFFC, then one free edge.
  - Required: PC=0, IFID_PCPlus4=0.
  - With IF_PERF_CNT_EN: FlushCount=1, FetchCount=1.
